instruction_memory: RTL and testbench

- Word-organised instruction store for the datapath's fetch stage.
- Byte-addressed 32-bit input Address selects one 32-bit word; the word is returned on Instruction after one clock.
- Contents power up and reset to a fixed test pattern.
- A synchronous write port lets the bench or loader overwrite words.

---
 rtl/instruction_memory.sv | 48 ++++
 tb/tb_instruction_memory.sv | 134 +++++++++++++
 2 files changed

// File: rtl/instruction_memory.sv
// Word-organised instruction store: byte-addressed, registered read with one cycle of latency,
// synchronous full-word write port. An async reset restores the i*3 test pattern.
module instruction_memory #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 128,
    parameter int unsigned IDX_W = 7
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [31:0]      Address,
    input  logic             WriteEnable,
    input  logic [31:0]      WriteAddress,
    input  logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] Instruction
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    // Byte-offset bits and bits above the array span are dropped, so addresses wrap.
    assign rd_idx = Address[IDX_W+1:2];
    assign wr_idx = WriteAddress[IDX_W+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{Address[31:IDX_W+2], Address[1:0],
                                WriteAddress[31:IDX_W+2], WriteAddress[1:0]};

    // Registered read. The nonblocking update of mem gives read-before-write on a shared index.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Instruction <= '0;
        end else begin
            Instruction <= mem[rd_idx];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= WIDTH'(i * 3);
            end
        end else if (WriteEnable) begin
            mem[wr_idx] <= WriteData;
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
// Directed self-checking bench for instruction_memory.
module tb_instruction_memory;

    logic        Clk;
    logic        Reset;
    logic [31:0] Address;
    logic        WriteEnable;
    logic [31:0] WriteAddress;
    logic [31:0] WriteData;
    logic [31:0] Instruction;

    int checks = 0;
    int errors = 0;

    instruction_memory #(
        .WIDTH(32),
        .DEPTH(128),
        .IDX_W(7)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Address     (Address),
        .WriteEnable (WriteEnable),
        .WriteAddress(WriteAddress),
        .WriteData   (WriteData),
        .Instruction (Instruction)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply an address on the falling edge, take one rising edge, sample on the next falling edge.
    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        Address = addr;
        @(posedge Clk);
        @(negedge Clk);
        check(tag, Instruction, exp);
    endtask

    initial begin
        Reset        = 1'b1;
        Address      = 32'h0;
        WriteEnable  = 1'b0;
        WriteAddress = 32'h0;
        WriteData    = 32'h0;

        #2;
        check("reset_out_async", Instruction, 32'h0);
        @(posedge Clk);
        #1;
        check("reset_out_after_edge", Instruction, 32'h0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        read_check("rd_word0", 32'h0000_0000, 32'h0000_0000);
        read_check("rd_word3_unaligned", 32'h0000_000F, 32'h0000_0009);
        read_check("rd_word7_unaligned", 32'h0000_001E, 32'h0000_0015);
        read_check("rd_addr3", 32'h0000_0003, 32'h0000_0000);
        read_check("rd_word1", 32'h0000_0004, 32'h0000_0003);
        read_check("rd_addr2", 32'h0000_0002, 32'h0000_0000);
        read_check("rd_word1_off3", 32'h0000_0007, 32'h0000_0003);
        read_check("rd_wrap_0x200", 32'h0000_0200, 32'h0000_0000);
        read_check("rd_word127", 32'h0000_01FC, 32'h0000_017D);
        read_check("rd_wrap_word2", 32'h0000_020B, 32'h0000_0006);
        read_check("rd_high_bits_word127", 32'h7FFF_FFFC, 32'h0000_017D);

        // Output must not move before the next rising edge.
        Address = 32'h0000_000C;
        #2;
        check("hold_before_edge", Instruction, 32'h0000_017D);
        @(posedge Clk);
        @(negedge Clk);
        check("latency_word3", Instruction, 32'h0000_0009);

        // Same-index read and write in one cycle: old word out, new word next read.
        WriteEnable  = 1'b1;
        WriteAddress = 32'h0000_0010;
        WriteData    = 32'hDEAD_BEEF;
        Address      = 32'h0000_0010;
        @(posedge Clk);
        @(negedge Clk);
        WriteEnable = 1'b0;
        check("rbw_old_word4", Instruction, 32'h0000_000C);
        read_check("rd_after_write", 32'h0000_0010, 32'hDEAD_BEEF);

        // Unaligned write address targets the containing word (word 10).
        WriteEnable  = 1'b1;
        WriteAddress = 32'h0000_002B;
        WriteData    = 32'h1234_5678;
        Address      = 32'h0000_0000;
        @(posedge Clk);
        @(negedge Clk);
        WriteEnable = 1'b0;
        read_check("rd_unaligned_write", 32'h0000_0028, 32'h1234_5678);
        read_check("rd_word11_untouched", 32'h0000_002C, 32'h0000_0021);
        read_check("rd_word4_still_new", 32'h0000_0010, 32'hDEAD_BEEF);

        // Async reset between edges clears the output at once.
        #2;
        Reset = 1'b1;
        #1;
        check("mid_cycle_reset_out", Instruction, 32'h0000_0000);

        // Writes during reset are ignored.
        WriteEnable  = 1'b1;
        WriteAddress = 32'h0000_0014;
        WriteData    = 32'hFFFF_FFFF;
        Address      = 32'h0000_0014;
        @(posedge Clk);
        #1;
        check("reset_held_out", Instruction, 32'h0000_0000);
        @(negedge Clk);
        WriteEnable = 1'b0;
        Reset       = 1'b0;

        read_check("restore_word4", 32'h0000_0010, 32'h0000_000C);
        read_check("no_write_in_reset", 32'h0000_0014, 32'h0000_000F);
        read_check("restore_word10", 32'h0000_0028, 32'h0000_001E);
        read_check("restore_word127", 32'h0000_01FC, 32'h0000_017D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
